// File: rtl/dmaster_st_pkg.sv
// Shared types and helpers for the dmaster Avalon-ST packet arbiter.
// Index widths are sized for the largest supported source count.
package dmaster_st_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  localparam int MAX_IN = 8;
  localparam int IDX_W  = $clog2(MAX_IN);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_IN-1:0] req,
    input logic [IDX_W-1:0]  ptr,
    input int                n
  );
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_IN; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !r.found && req[j[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dmaster_st_packet_arbiter_picker.sv
// Combinational round-robin selector: request vector plus pointer in,
// one-hot grant and binary index out.
module dmaster_rr_picker
  import dmaster_st_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_IN'(req), ptr, NUM_IN);
    found = pick.found;
    idx   = pick.idx;
    gnt   = '0;
    if (pick.found) begin
      gnt = NUM_IN'(1) << pick.idx;
    end
  end

endmodule

// File: rtl/dmaster_st_packet_arbiter.sv
// Packet-boundary round-robin mux of NUM_IN Avalon-ST byte streams
// with channel tagging and one registered output stage.
module dmaster_st_packet_arbiter
  import dmaster_st_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     err_orphan,
  output logic                     busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic              stage_free;
  logic [NUM_IN-1:0] sop_req;
  logic [NUM_IN-1:0] orph_req;
  logic [NUM_IN-1:0] win_gnt;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  rr_pick_t          orph;

  logic [NUM_IN-1:0] rdy;
  logic [NUM_IN-1:0] sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic              load;
  logic              orph_take;
  logic [DATA_W-1:0] mux_data;
  logic              mux_sop;
  logic              mux_eop;

  function automatic logic [IDX_W-1:0] ptr_inc(
    input logic [IDX_W-1:0] p
  );
    return (p == IDX_W'(NUM_IN - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign stage_free = !out_valid || out_ready;
  assign sop_req    = in_valid & in_startofpacket;
  assign orph_req   = in_valid & ~in_startofpacket;
  assign busy       = (state_q == ST_LOCKED);

  dmaster_rr_picker #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req   (sop_req),
    .ptr   (ptr_q),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .found (win_found)
  );

  // Orphans drain lowest-index first, independent of the pointer.
  assign orph = rr_pick(MAX_IN'(orph_req), '0, NUM_IN);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_oh[i]) begin
        mux_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mux_sop = |(in_startofpacket & sel_oh);
  assign mux_eop = |(in_endofpacket & sel_oh);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    rdy       = '0;
    sel_oh    = '0;
    sel_idx   = grant_q;
    load      = 1'b0;
    orph_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_oh  = win_gnt;
          sel_idx = win_idx;
          if (stage_free) begin
            rdy  = win_gnt;
            load = 1'b1;
            if (|(in_endofpacket & win_gnt)) begin
              ptr_d = ptr_inc(win_idx);
            end else begin
              state_d = ST_LOCKED;
              grant_d = win_idx;
            end
          end
        end else if (orph.found) begin
          rdy       = NUM_IN'(1) << orph.idx;
          orph_take = 1'b1;
        end
      end
      ST_LOCKED: begin
        sel_oh = NUM_IN'(1) << grant_q;
        if (stage_free) begin
          rdy = sel_oh;
          if (|(in_valid & sel_oh)) begin
            load = 1'b1;
            if (mux_eop) begin
              state_d = ST_IDLE;
              ptr_d   = ptr_inc(grant_q);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hold ready low while reset is asserted, not just after the edge.
  assign in_ready = rdy & {NUM_IN{reset_n}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= mux_data;
      out_channel       <= CHANNEL_W'(sel_idx);
      out_startofpacket <= mux_sop;
      out_endofpacket   <= mux_eop;
    end else if (stage_free) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_orphan <= 1'b0;
    end else if (orph_take) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmaster_st_packet_arbiter.sv
// Directed self-checking bench for dmaster_st_packet_arbiter.
// Expected values are hand-derived per step.
module tb_dmaster_st_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_sop;
  logic [N-1:0]  in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_channel;
  logic          out_sop;
  logic          out_eop;
  logic          err_orphan;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmaster_st_packet_arbiter #(
    .NUM_IN    (N),
    .DATA_W    (DW),
    .CHANNEL_W (CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .err_orphan        (err_orphan),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic v, input logic [7:0] d,
                     input logic s, input logic e);
    in_valid[i]        = v;
    in_data[i*DW +: DW] = d;
    in_sop[i]          = s;
    in_eop[i]          = e;
  endtask

  task automatic clr();
    in_valid = '0;
    in_data  = '0;
    in_sop   = '0;
    in_eop   = '0;
  endtask

  task automatic beat(input string tag, input logic [7:0] d,
                      input logic [7:0] ch, input logic s,
                      input logic e);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    chk({tag, "_ch"}, 32'(out_channel), 32'(ch));
    chk({tag, "_sop"}, 32'(out_sop), 32'(s));
    chk({tag, "_eop"}, 32'(out_eop), 32'(e));
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clr();
    src(0, 1'b1, 8'h55, 1'b1, 1'b0);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_channel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_orphan), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    clr();
    tick();
    @(negedge clk);
    reset_n = 1'b1;

    // Single source 2, three beats.
    src(2, 1'b1, 8'h11, 1'b1, 1'b0);
    #1 chk("t1_rdy0", 32'(in_ready), 32'b0100);
    tick();
    beat("t1_b0", 8'h11, 8'd2, 1'b1, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    src(2, 1'b1, 8'h22, 1'b0, 1'b0);
    #1 chk("t1_rdy1", 32'(in_ready), 32'b0100);
    tick();
    beat("t1_b1", 8'h22, 8'd2, 1'b0, 1'b0);
    src(2, 1'b1, 8'h33, 1'b0, 1'b1);
    tick();
    beat("t1_b2", 8'h33, 8'd2, 1'b0, 1'b1);
    chk("t1_idle", 32'(busy), 32'd0);
    clr();
    tick();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // Sources 0 and 1 contend; no interleave.
    src(0, 1'b1, 8'hA0, 1'b1, 1'b0);
    src(1, 1'b1, 8'hB0, 1'b1, 1'b0);
    #1 chk("t2_rdy0", 32'(in_ready), 32'b0001);
    tick();
    beat("t2_a0", 8'hA0, 8'd0, 1'b1, 1'b0);
    src(0, 1'b1, 8'hA1, 1'b0, 1'b1);
    #1 chk("t2_rdy1", 32'(in_ready), 32'b0001);
    tick();
    beat("t2_a1", 8'hA1, 8'd0, 1'b0, 1'b1);
    src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("t2_rdy2", 32'(in_ready), 32'b0010);
    tick();
    beat("t2_b0", 8'hB0, 8'd1, 1'b1, 1'b0);
    src(1, 1'b1, 8'hB1, 1'b0, 1'b1);
    tick();
    beat("t2_b1", 8'hB1, 8'd1, 1'b0, 1'b1);
    clr();
    tick();
    chk("t2_drain", 32'(out_valid), 32'd0);

    // Single-beat from source 3 moves the pointer to 0.
    src(3, 1'b1, 8'h3F, 1'b1, 1'b1);
    #1 chk("t3_rdy_pre", 32'(in_ready), 32'b1000);
    tick();
    beat("t3_pre", 8'h3F, 8'd3, 1'b1, 1'b1);
    chk("t3_pre_busy", 32'(busy), 32'd0);

    // All sources offer single-beat packets continuously.
    for (int i = 0; i < N; i++) begin
      src(i, 1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      #1 chk("t3_rdy", 32'(in_ready), 32'(4'b0001 << (k % N)));
      tick();
      beat("t3_rr", 8'(8'hC0 + (k % N)), 8'(k % N), 1'b1, 1'b1);
    end
    clr();
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // Locked on source 1 with a five-cycle downstream stall.
    src(1, 1'b1, 8'hD0, 1'b1, 1'b0);
    tick();
    beat("t4_d0", 8'hD0, 8'd1, 1'b1, 1'b0);
    src(1, 1'b1, 8'hD1, 1'b0, 1'b0);
    tick();
    beat("t4_d1", 8'hD1, 8'd1, 1'b0, 1'b0);
    out_ready = 1'b0;
    src(1, 1'b1, 8'hD2, 1'b0, 1'b0);
    src(2, 1'b1, 8'hEE, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4_stall_rdy", 32'(in_ready), 32'd0);
      tick();
      chk("t4_stall_v", 32'(out_valid), 32'd1);
      chk("t4_stall_d", 32'(out_data), 32'hD1);
    end
    out_ready = 1'b1;
    #1 chk("t4_rel_rdy", 32'(in_ready), 32'b0010);
    tick();
    beat("t4_d2", 8'hD2, 8'd1, 1'b0, 1'b0);
    src(1, 1'b1, 8'hD3, 1'b0, 1'b1);
    tick();
    beat("t4_d3", 8'hD3, 8'd1, 1'b0, 1'b1);
    chk("t4_busy", 32'(busy), 32'd0);
    clr();
    tick();
    chk("t4_drain", 32'(out_valid), 32'd0);

    // Orphan beat on source 3 while idle.
    src(3, 1'b1, 8'hAA, 1'b0, 1'b0);
    #1 chk("t5_rdy", 32'(in_ready), 32'b1000);
    tick();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_err", 32'(err_orphan), 32'd1);
    clr();
    tick();
    tick();
    chk("t5_err_hold", 32'(err_orphan), 32'd1);
    chk("t5_valid2", 32'(out_valid), 32'd0);

    // Reset mid-packet, then a fresh packet from source 0.
    src(0, 1'b1, 8'hE0, 1'b1, 1'b0);
    tick();
    beat("t6_e0", 8'hE0, 8'd0, 1'b1, 1'b0);
    src(0, 1'b1, 8'hE1, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rdy", 32'(in_ready), 32'd0);
    chk("t6_err", 32'(err_orphan), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    src(0, 1'b1, 8'hF0, 1'b1, 1'b0);
    #1 chk("t6_rdy_new", 32'(in_ready), 32'b0001);
    tick();
    beat("t6_f0", 8'hF0, 8'd0, 1'b1, 1'b0);
    chk("t6_busy_new", 32'(busy), 32'd1);
    clr();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
